// File: rtl/warp_scan_ctrl.sv
// warp_scan_ctrl: raster sequencer for the homography warp unit.
// Walks the output frame pixel by pixel, issues each (x, y) to the warp unit,
// waits for its ready (with a watchdog), then writes the returned RGB565 pixel.
`timescale 1ns/1ps

module warp_scan_ctrl #(
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFRAME_START,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oSTART,
    input  logic        iREADY,
    input  logic [4:0]  iR,
    input  logic [5:0]  iG,
    input  logic [4:0]  iB,
    output logic        oWR,
    output logic [9:0]  oWR_X,
    output logic [9:0]  oWR_Y,
    output logic [15:0] oWR_DATA,
    input  logic        iWR_ACK
);

    localparam int unsigned CW     = 10;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     x_cnt, x_n;
    logic [CW-1:0]     y_cnt, y_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic              err_q, err_n;
    logic [15:0]       data_q, data_n;
    logic              busy_q, done_q, start_q, wr_q;

    logic x_end;
    logic last_px;

    // Raster position decode for wrap and end-of-frame
    assign x_end   = (x_cnt == CW'(H_ACT - 1));
    assign last_px = x_end && (y_cnt == CW'(V_ACT - 1));

    // Next-state, counter and data-path decisions
    always_comb begin
        state_n = state;
        x_n     = x_cnt;
        y_n     = y_cnt;
        wait_n  = wait_cnt;
        err_n   = err_q;
        data_n  = data_q;
        case (state)
            IDLE: begin
                if (iFRAME_START) begin
                    x_n     = '0;
                    y_n     = '0;
                    wait_n  = '0;
                    err_n   = 1'b0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                wait_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // ready takes priority over a watchdog expiry in the same cycle
                if (iREADY) begin
                    data_n  = {iR, iG, iB};
                    state_n = WRITE;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    data_n  = 16'h0000;
                    state_n = WRITE;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            WRITE: begin
                if (iWR_ACK) begin
                    if (last_px) begin
                        // park the raster at the origin once the frame completes
                        x_n     = '0;
                        y_n     = '0;
                        state_n = DONE;
                    end else begin
                        if (x_end) begin
                            x_n = '0;
                            y_n = y_cnt + CW'(1);
                        end else begin
                            x_n = x_cnt + CW'(1);
                        end
                        state_n = ISSUE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs (strobes decoded from next state)
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state    <= state_n;
            x_cnt    <= x_n;
            y_cnt    <= y_n;
            wait_cnt <= wait_n;
            err_q    <= err_n;
            data_q   <= data_n;
            busy_q   <= (state_n == ISSUE) || (state_n == WAIT) || (state_n == WRITE);
            done_q   <= (state_n == DONE);
            start_q  <= (state_n == ISSUE);
            wr_q     <= (state_n == WRITE);
        end
    end

    assign oBUSY    = busy_q;
    assign oDONE    = done_q;
    assign oERR     = err_q;
    assign oSTART   = start_q;
    assign oX       = x_cnt;
    assign oY       = y_cnt;
    assign oWR      = wr_q;
    assign oWR_X    = x_cnt;
    assign oWR_Y    = y_cnt;
    assign oWR_DATA = data_q;

endmodule

// File: tb/tb_warp_scan_ctrl.sv
// Testbench for warp_scan_ctrl: a 4x2 frame (TIMEOUT=8) driven from a vector
// table and per-pixel sequences, plus a 1x1 instance (TIMEOUT=2).
`timescale 1ns/1ps

module tb_warp_scan_ctrl;

    localparam int H = 4;
    localparam int V = 2;

    localparam logic [4:0] F_IDLE  = 5'b00000;  // {busy, done, err, start, wr}
    localparam logic [4:0] F_ISSUE = 5'b10010;
    localparam logic [4:0] F_WAIT  = 5'b10000;
    localparam logic [4:0] F_WRITE = 5'b10001;
    localparam logic [4:0] F_DONE  = 5'b01000;
    localparam logic [4:0] F_ERR   = 5'b00100;

    typedef struct {
        logic        fs;
        logic        rdy;
        logic [15:0] rgb;
        logic        ack;
        logic [4:0]  ef;
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic [15:0] ed;
        string       nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fs = 1'b0, rdy = 1'b0, ack = 1'b0;
    logic [4:0] r = '0, b = '0;
    logic [5:0] g = '0;
    logic busy, done, err, start, wr;
    logic [9:0] x, y, wr_x, wr_y;
    logic [15:0] wdata;

    logic fs1 = 1'b0, rdy1 = 1'b0, ack1 = 1'b0;
    logic [4:0] r1 = '0, b1 = '0;
    logic [5:0] g1 = '0;
    logic busy1, done1, err1, start1, wr1;
    logic [9:0] x1, y1, wr_x1, wr_y1;
    logic [15:0] wdata1;

    int n_cmp = 0;
    int n_bad = 0;
    int nsteps = 0;
    int last_done_step = -1;
    int wr_total = 0;
    int start_total = 0;

    always #5 clk = ~clk;

    warp_scan_ctrl #(.H_ACT(H), .V_ACT(V), .TIMEOUT(8)) dut (
        .iCLK(clk), .iRST(rst), .iFRAME_START(fs),
        .oBUSY(busy), .oDONE(done), .oERR(err), .oX(x), .oY(y), .oSTART(start),
        .iREADY(rdy), .iR(r), .iG(g), .iB(b),
        .oWR(wr), .oWR_X(wr_x), .oWR_Y(wr_y), .oWR_DATA(wdata), .iWR_ACK(ack)
    );

    warp_scan_ctrl #(.H_ACT(1), .V_ACT(1), .TIMEOUT(2)) dut1 (
        .iCLK(clk), .iRST(rst), .iFRAME_START(fs1),
        .oBUSY(busy1), .oDONE(done1), .oERR(err1), .oX(x1), .oY(y1), .oSTART(start1),
        .iREADY(rdy1), .iR(r1), .iG(g1), .iB(b1),
        .oWR(wr1), .oWR_X(wr_x1), .oWR_Y(wr_y1), .oWR_DATA(wdata1), .iWR_ACK(ack1)
    );

    // Count accepted writes and start strobes of the main instance
    always @(posedge clk) begin
        if (wr && ack) wr_total <= wr_total + 1;
        if (start) start_total <= start_total + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic vec_t mk(input logic fs_v, input logic rdy_v, input logic [15:0] rgb_v,
                                input logic ack_v, input logic [4:0] ef, input int ex, input int ey,
                                input logic [15:0] ed, input string nm);
        vec_t v;
        v.fs = fs_v; v.rdy = rdy_v; v.rgb = rgb_v; v.ack = ack_v;
        v.ef = ef; v.ex = 10'(ex); v.ey = 10'(ey); v.ed = ed; v.nm = nm;
        return v;
    endfunction

    task automatic check_val(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // One clock on the main instance: drive, clock, then compare outputs
    task automatic step(input logic rst_v, input logic fs_v, input logic rdy_v,
                        input logic [15:0] rgb_v, input logic ack_v, input logic [4:0] ef,
                        input logic [9:0] ex, input logic [9:0] ey, input logic [15:0] ed,
                        input string nm);
        logic [4:0] af;
        bit bad;
        @(negedge clk);
        rst = rst_v; fs = fs_v; rdy = rdy_v; ack = ack_v;
        r = rgb_v[15:11]; g = rgb_v[10:5]; b = rgb_v[4:0];
        @(posedge clk);
        #1;
        nsteps++;
        if (done) last_done_step = nsteps;
        af  = {busy, done, err, start, wr};
        bad = (af != ef);
        if (ef[4] && !ef[0] && (x != ex || y != ey)) bad = 1'b1;
        if (ef[0] && (wr_x != ex || wr_y != ey || wdata != ed)) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got flags=%b x=%0d y=%0d wr_xy=%0d,%0d data=%h, want flags=%b xy=%0d,%0d data=%h",
                     nm, af, x, y, wr_x, wr_y, wdata, ef, ex, ey, ed);
        end
    endtask

    task automatic check_all_zero(input string nm);
        n_cmp++;
        if ({busy, done, err, start, wr, x, y, wr_x, wr_y, wdata} != '0) begin
            n_bad++;
            $display("FAIL %s: got flags=%b x=%0d y=%0d wr_xy=%0d,%0d data=%h, want all zero",
                     nm, {busy, done, err, start, wr}, x, y, wr_x, wr_y, wdata);
        end
    endtask

    // One pixel starting from an observed ISSUE cycle for (px, py)
    task automatic pixel(input int px, input int py, input int rd, input int ad, input bit noise,
                         input logic [15:0] rgb, input bit e);
        logic [4:0] eb;
        int nx, ny;
        bit last;
        eb   = e ? F_ERR : F_IDLE;
        last = (px == H - 1) && (py == V - 1);
        nx   = (px == H - 1) ? 0 : px + 1;
        ny   = (px == H - 1) ? py + 1 : py;
        step(1'b0, noise, noise, 16'hFFFF, 1'b0, F_WAIT | eb, 10'(px), 10'(py), 16'h0,
             $sformatf("enter_wait(%0d,%0d)", px, py));
        for (int i = 0; i < rd; i++)
            step(1'b0, noise, 1'b0, rgb, 1'b0, F_WAIT | eb, 10'(px), 10'(py), 16'h0,
                 $sformatf("wait_hold(%0d,%0d)", px, py));
        step(1'b0, 1'b0, 1'b1, rgb, 1'b0, F_WRITE | eb, 10'(px), 10'(py), rgb,
             $sformatf("write(%0d,%0d)", px, py));
        for (int i = 0; i < ad; i++)
            step(1'b0, noise, noise, ~rgb, 1'b0, F_WRITE | eb, 10'(px), 10'(py), rgb,
                 $sformatf("write_hold(%0d,%0d)", px, py));
        if (last)
            step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, F_DONE | eb, 10'd0, 10'd0, 16'h0, "frame_done");
        else
            step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, F_ISSUE | eb, 10'(nx), 10'(ny), 16'h0,
                 $sformatf("next_issue(%0d,%0d)", nx, ny));
    endtask

    task automatic clean_frame();
        for (int py = 0; py < V; py++)
            for (int px = 0; px < H; px++)
                pixel(px, py, 0, 0, 1'b0,
                      (px == 2 && py == 1) ? 16'hF801 : 16'(16'h1000 * px + 16'h0100 * py + 16'h0033),
                      1'b0);
    endtask

    // One clock on the 1x1 instance
    task automatic step1(input logic fs_v, input logic rdy_v, input logic [15:0] rgb_v,
                         input logic ack_v, input logic [4:0] ef, input logic [15:0] ed,
                         input string nm);
        logic [4:0] af;
        bit bad;
        @(negedge clk);
        fs1 = fs_v; rdy1 = rdy_v; ack1 = ack_v;
        r1 = rgb_v[15:11]; g1 = rgb_v[10:5]; b1 = rgb_v[4:0];
        @(posedge clk);
        #1;
        af  = {busy1, done1, err1, start1, wr1};
        bad = (af != ef);
        if (ef[4] && !ef[0] && (x1 != 10'd0 || y1 != 10'd0)) bad = 1'b1;
        if (ef[0] && (wr_x1 != 10'd0 || wr_y1 != 10'd0 || wdata1 != ed)) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got flags=%b x=%0d y=%0d data=%h, want flags=%b data=%h",
                     nm, af, x1, y1, wdata1, ef, ed);
        end
    endtask

    vec_t tbl[16];
    int   wr_base, st_base, t0;

    initial begin
        tbl[0]  = mk(1'b0, 1'b1, 16'hFFFF, 1'b1, F_IDLE,  0, 0, 16'h0,    "idle_ignore");
        tbl[1]  = mk(1'b1, 1'b0, 16'h0,    1'b0, F_ISSUE, 0, 0, 16'h0,    "first_issue");
        tbl[2]  = mk(1'b0, 1'b0, 16'h0,    1'b0, F_WAIT,  0, 0, 16'h0,    "wait00");
        tbl[3]  = mk(1'b0, 1'b1, 16'h52A3, 1'b0, F_WRITE, 0, 0, 16'h52A3, "write00");
        tbl[4]  = mk(1'b0, 1'b0, 16'h0,    1'b0, F_WRITE, 0, 0, 16'h52A3, "write00_hold");
        tbl[5]  = mk(1'b0, 1'b0, 16'h0,    1'b1, F_ISSUE, 1, 0, 16'h0,    "issue10");
        tbl[6]  = mk(1'b1, 1'b1, 16'hFFFF, 1'b0, F_WAIT,  1, 0, 16'h0,    "wait10_stale_ready");
        for (int i = 7; i <= 13; i++)
            tbl[i] = mk(1'b0, 1'b0, 16'h0, 1'b0, F_WAIT, 1, 0, 16'h0, $sformatf("wait10_cycle%0d", i - 5));
        tbl[14] = mk(1'b0, 1'b0, 16'h0,    1'b0, F_WRITE | F_ERR, 1, 0, 16'h0000, "timeout_write10");
        tbl[15] = mk(1'b0, 1'b0, 16'h0,    1'b1, F_ISSUE | F_ERR, 2, 0, 16'h0,    "issue20_err");

        // Reset
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, F_IDLE, 10'd0, 10'd0, 16'h0, "reset0");
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, F_IDLE, 10'd0, 10'd0, 16'h0, "reset1");
        check_all_zero("reset_outputs");
        wr_base = wr_total;
        st_base = start_total;

        // Frame 1: table covers (0,0) and the (1,0) timeout
        for (int i = 0; i < 16; i++)
            step(1'b0, tbl[i].fs, tbl[i].rdy, tbl[i].rgb, tbl[i].ack, tbl[i].ef,
                 tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].nm);
        pixel(2, 0, 1, 5, 1'b1, 16'h7BEF, 1'b1);
        pixel(3, 0, 0, 0, 1'b0, 16'h1111, 1'b1);
        pixel(0, 1, 2, 0, 1'b1, 16'h2222, 1'b1);
        pixel(1, 1, 0, 1, 1'b0, 16'h3333, 1'b1);
        pixel(2, 1, 0, 0, 1'b1, 16'hF801, 1'b1);
        pixel(3, 1, 0, 2, 1'b1, 16'h4444, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, F_IDLE | F_ERR, 10'd0, 10'd0, 16'h0, "err_sticky_idle");
        check_val("frame1_writes", wr_total - wr_base, H * V);
        check_val("frame1_starts", start_total - st_base, H * V);

        // Frame 2: minimum pacing, error cleared by the new start
        wr_base = wr_total;
        last_done_step = -1;
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, F_ISSUE, 10'd0, 10'd0, 16'h0, "frame2_start_err_clear");
        t0 = nsteps;
        clean_frame();
        check_val("done_latency", last_done_step - t0 + 1, 25);
        check_val("frame2_writes", wr_total - wr_base, H * V);

        // Frame 3: reset while (3,0) is writing
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, F_IDLE, 10'd0, 10'd0, 16'h0, "idle_f3");
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, F_ISSUE, 10'd0, 10'd0, 16'h0, "frame3_start");
        pixel(0, 0, 0, 0, 1'b0, 16'hA5A5, 1'b0);
        pixel(1, 0, 0, 0, 1'b0, 16'h5A5A, 1'b0);
        pixel(2, 0, 0, 0, 1'b0, 16'h0F0F, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, F_WAIT, 10'd3, 10'd0, 16'h0, "wait30");
        step(1'b0, 1'b0, 1'b1, 16'hC3C3, 1'b0, F_WRITE, 10'd3, 10'd0, 16'hC3C3, "write30");
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, F_IDLE, 10'd0, 10'd0, 16'h0, "reset_in_write");
        check_all_zero("reset_in_write_zero");
        last_done_step = -1;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, F_IDLE, 10'd0, 10'd0, 16'h0, "post_reset_idle");
        check_val("no_done_after_reset", last_done_step, -1);

        // Frame 4: restarts from the origin and completes
        wr_base = wr_total;
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, F_ISSUE, 10'd0, 10'd0, 16'h0, "frame4_start");
        clean_frame();
        check_val("frame4_writes", wr_total - wr_base, H * V);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, F_IDLE, 10'd0, 10'd0, 16'h0, "idle_after_f4");

        // 1x1 frame, TIMEOUT=2: timeout, then ready exactly at expiry
        step1(1'b1, 1'b0, 16'h0, 1'b0, F_ISSUE, 16'h0, "one_issue");
        step1(1'b0, 1'b0, 16'h0, 1'b0, F_WAIT, 16'h0, "one_wait0");
        step1(1'b0, 1'b0, 16'h0, 1'b0, F_WAIT, 16'h0, "one_wait1");
        step1(1'b0, 1'b0, 16'h0, 1'b0, F_WRITE | F_ERR, 16'h0000, "one_timeout_write");
        step1(1'b0, 1'b0, 16'h0, 1'b1, F_DONE | F_ERR, 16'h0, "one_done_err");
        step1(1'b0, 1'b0, 16'h0, 1'b0, F_IDLE | F_ERR, 16'h0, "one_idle_err");
        step1(1'b1, 1'b0, 16'h0, 1'b0, F_ISSUE, 16'h0, "one_restart_clear");
        step1(1'b0, 1'b0, 16'h0, 1'b0, F_WAIT, 16'h0, "one_wait0b");
        step1(1'b0, 1'b0, 16'h0, 1'b0, F_WAIT, 16'h0, "one_wait1b");
        step1(1'b0, 1'b1, 16'hABCD, 1'b0, F_WRITE, 16'hABCD, "one_ready_at_expiry");
        step1(1'b0, 1'b0, 16'h0, 1'b1, F_DONE, 16'h0, "one_done_clean");
        step1(1'b0, 1'b0, 16'h0, 1'b0, F_IDLE, 16'h0, "one_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
